// File: rtl/st_to_onchip_mem_writer_pkg.sv
// rtl/st_to_onchip_mem_writer_pkg.sv - shared types and helpers for the stream-to-memory writer
package st_to_onchip_mem_writer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int LANES  = 4;
  localparam int BYTE_W = 8;

  // Number of filled lanes (1..4) to a contiguous low-aligned lane mask.
  function automatic logic [LANES-1:0] lanes_to_byteenable(input logic [2:0] count);
    logic [LANES-1:0] be;
    be = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i < int'(count)) be[i] = 1'b1;
    end
    return be;
  endfunction

endpackage

// File: rtl/st_word_packer.sv
// rtl/st_word_packer.sv - packs accepted bytes little-endian into 32-bit words
module st_word_packer
  import st_to_onchip_mem_writer_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    accept,
  input  logic [BYTE_W-1:0]       byte_data,
  input  logic                    eop,
  output logic                    word_ready,
  output logic                    flush,
  output logic [LANES*BYTE_W-1:0] word_data,
  output logic [LANES-1:0]        word_be
);

  logic [1:0]              lane;
  logic [LANES*BYTE_W-1:0] pack;
  logic [LANES*BYTE_W-1:0] merged;

  // Drop the incoming byte into its lane; lanes not yet filled stay zero.
  always_comb begin
    merged = pack;
    case (lane)
      2'd0:    merged[7:0]   = byte_data;
      2'd1:    merged[15:8]  = byte_data;
      2'd2:    merged[23:16] = byte_data;
      default: merged[31:24] = byte_data;
    endcase
  end

  assign word_ready = accept & ((lane == 2'd3) | eop);
  assign flush      = accept & eop;
  assign word_data  = merged;
  assign word_be    = lanes_to_byteenable({1'b0, lane} + 3'd1);

  // Lane counter and pack register; emptied as soon as a word is handed off so packing never stalls.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lane <= 2'd0;
      pack <= '0;
    end else if (word_ready) begin
      lane <= 2'd0;
      pack <= '0;
    end else if (accept) begin
      lane <= lane + 2'd1;
      pack <= merged;
    end
  end

endmodule

// File: rtl/st_to_onchip_mem_writer.sv
// rtl/st_to_onchip_mem_writer.sv - byte stream to single-port on-chip memory word writer
module st_to_onchip_mem_writer
  import st_to_onchip_mem_writer_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int DEPTH_WORDS = 1024,
  parameter int BASE_ADDR   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [10:0]       len_words,
  input  logic              abort,
  input  logic [7:0]        snk_data,
  input  logic              snk_valid,
  input  logic              snk_eop,
  output logic              snk_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              busy,
  output logic              done,
  output logic [10:0]       words_written
);

  state_t      state, state_next;
  logic [10:0] len_q;
  logic [10:0] word_idx;
  logic [10:0] len_clamped;
  logic        start_ok, accept, word_ready, flush, issue, last_word;
  logic [31:0] word_data;
  logic [3:0]  word_be;

  assign start_ok    = (state == IDLE) & start;
  assign snk_ready   = (state == PACK);
  assign busy        = (state == PACK) | (state == DRAIN);
  assign accept      = snk_valid & snk_ready;
  assign issue       = word_ready & ~abort;
  assign last_word   = issue & (flush | (word_idx == len_q - 11'd1));
  assign len_clamped = (32'(len_words) > DEPTH_WORDS) ? 11'(DEPTH_WORDS) : len_words;

  st_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (abort | start_ok),
    .accept     (accept),
    .byte_data  (snk_data),
    .eop        (snk_eop),
    .word_ready (word_ready),
    .flush      (flush),
    .word_data  (word_data),
    .word_be    (word_be)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state: zero-length starts never leave IDLE; abort wins over a final word in the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && (len_words != 11'd0)) state_next = PACK;
      PACK: begin
        if (abort)          state_next = IDLE;
        else if (last_word) state_next = DRAIN;
      end
      DRAIN:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Memory write port, transfer counters and status; a write registered before an abort still goes out.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_address    <= '0;
      mem_byteenable <= '0;
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      mem_writedata  <= '0;
      done           <= 1'b0;
      words_written  <= '0;
      len_q          <= '0;
      word_idx       <= '0;
    end else begin
      mem_write      <= issue;
      mem_chipselect <= issue;
      if (issue) begin
        mem_address    <= ADDR_W'(BASE_ADDR + 32'(word_idx));
        mem_byteenable <= word_be;
        mem_writedata  <= word_data;
        word_idx       <= word_idx + 11'd1;
      end
      done <= (start_ok && (len_words == 11'd0)) || ((state != IDLE) && abort) || (state == DRAIN);
      if (start_ok && (len_words != 11'd0)) begin
        len_q         <= len_clamped;
        word_idx      <= '0;
        words_written <= '0;
      end else if (mem_write) begin
        words_written <= words_written + 11'd1;
      end
    end
  end

endmodule

// File: tb/tb_st_to_onchip_mem_writer.sv
// tb/tb_st_to_onchip_mem_writer.sv - scoreboard bench for the stream-to-memory writer
module tb_st_to_onchip_mem_writer;

  localparam int BASE  = 1022;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset, start, abort, snk_valid, snk_eop;
  logic [10:0] len_words;
  logic [7:0]  snk_data;
  logic        snk_ready, mem_chipselect, mem_write, busy, done;
  logic [9:0]  mem_address;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata;
  logic [10:0] words_written;

  st_to_onchip_mem_writer #(.ADDR_W(10), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .start(start), .len_words(len_words), .abort(abort),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_eop(snk_eop), .snk_ready(snk_ready),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .busy(busy), .done(done),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  addr;
    logic [3:0]  be;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks = 0;
  int  fails = 0;
  int  cyc = 0;
  int  last_wr_cyc = -10;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every memory write is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (!reset && (mem_write || mem_chipselect)) begin
      chk("chipselect_eq_write", mem_chipselect, mem_write);
      if (mem_write) begin
        last_wr_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_write: got addr %0d data %0h expected no write", mem_address, mem_writedata);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", 32'(mem_address), 32'(mon_e.addr));
          chk("wr_be", 32'(mem_byteenable), 32'(mon_e.be));
          chk("wr_data", mem_writedata, mon_e.data);
        end
      end
    end
  end

  // Reference: group bytes into words of four, close a word early on eop, stop at clamped length or eop.
  function automatic void model(input logic [7:0] b[$], input bit eo[$], input int len,
                                output int used, output int nw);
    int eff;
    int cnt;
    logic [31:0] w;
    wr_t x;
    eff = (len > DEPTH) ? DEPTH : len;
    cnt = 0;
    w = 0;
    used = 0;
    nw = 0;
    for (int i = 0; i < b.size(); i++) begin
      w = w | (32'(b[i]) << (8 * cnt));
      cnt++;
      used = i + 1;
      if (cnt == 4 || eo[i]) begin
        x.addr = 10'((BASE + nw) % DEPTH);
        x.be   = 4'((1 << cnt) - 1);
        x.data = w;
        exp_q.push_back(x);
        nw++;
        w = 0;
        cnt = 0;
        if (nw == eff || eo[i]) break;
      end
    end
  endfunction

  task automatic do_start(input int len);
    start = 1'b1;
    len_words = 11'(len);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit e, input int max_gap);
    bit ok;
    int gap;
    ok = 0;
    gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk);
      #1;
    end
    snk_valid = 1'b1;
    snk_data = d;
    snk_eop = e;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (snk_ready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    snk_valid = 1'b0;
    snk_eop = 1'b0;
    if (!ok) begin
      checks++;
      fails++;
      $display("FAIL byte_accept_timeout: got snk_ready 0 expected 1");
    end
  endtask

  task automatic wait_done(input int exp_ww, input bit chk_ww, input bit timed, output int k_seen);
    bit seen;
    seen = 0;
    k_seen = -1;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        k_seen = k;
        break;
      end
    end
    if (!seen) begin
      checks++;
      fails++;
      $display("FAIL done_timeout: got no done expected done pulse");
    end else begin
      if (chk_ww) chk("words_written", 32'(words_written), 32'(exp_ww));
      chk("busy_at_done", 32'(busy), 0);
      if (timed) chk("done_after_last_write", 32'(cyc - last_wr_cyc), 1);
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_xfer(input logic [7:0] b[$], input bit eo[$], input int len,
                          input int gap, input bit hold_valid);
    int used, nw, k;
    model(b, eo, len, used, nw);
    do_start(len);
    for (int i = 0; i < used; i++) send_byte(b[i], eo[i], gap);
    if (hold_valid) snk_valid = 1'b1;
    wait_done(nw, 1, 1, k);
  endtask

  logic [7:0] bq[$];
  bit         eq[$];
  int         k0, used0, nw0;

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; snk_valid = 1'b0; snk_eop = 1'b0;
    len_words = '0; snk_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_write", 32'(mem_write), 0);
    chk("rst_mem_cs", 32'(mem_chipselect), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_snk_ready", 32'(snk_ready), 0);
    chk("rst_words_written", 32'(words_written), 0);
    chk("rst_mem_address", 32'(mem_address), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    // Two full words back to back.
    bq.delete(); eq.delete();
    for (int i = 1; i <= 8; i++) begin bq.push_back(8'(i)); eq.push_back(0); end
    run_xfer(bq, eq, 2, 0, 0);

    // Partial word closed by eop.
    bq = '{8'hAA, 8'hBB, 8'hCC};
    eq = '{0, 0, 1};
    run_xfer(bq, eq, 4, 0, 0);

    // Address wrap across the top of memory.
    bq.delete(); eq.delete();
    for (int i = 0; i < 12; i++) begin bq.push_back(8'($urandom)); eq.push_back(0); end
    run_xfer(bq, eq, 3, 1, 0);

    // Zero length: done next cycle, nothing written.
    do_start(0);
    wait_done(0, 0, 0, k0);
    chk("len0_done_latency", 32'(k0), 0);

    // Randomized transfers with gaps and occasional early eop.
    for (int r = 0; r < 8; r++) begin
      int len;
      len = int'($urandom_range(1, 6));
      bq.delete(); eq.delete();
      for (int i = 0; i < len * 4 + 2; i++) begin
        bq.push_back(8'($urandom));
        eq.push_back($urandom_range(0, 7) == 0);
      end
      run_xfer(bq, eq, len, 2, 0);
    end

    // Oversized length is clamped to memory depth; stream stays blocked afterwards.
    bq.delete(); eq.delete();
    for (int i = 0; i < 4 * DEPTH; i++) begin bq.push_back(8'($urandom)); eq.push_back(0); end
    run_xfer(bq, eq, 2000, 0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ready_low_after_clamp", 32'(snk_ready), 0);
    end
    @(posedge clk);
    #1 snk_valid = 1'b0;

    // Abort after five bytes of a four-word transfer.
    bq.delete(); eq.delete();
    for (int i = 0; i < 5; i++) begin bq.push_back(8'($urandom)); eq.push_back(0); end
    model(bq, eq, 4, used0, nw0);
    do_start(4);
    for (int i = 0; i < 5; i++) send_byte(bq[i], 0, 0);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    wait_done(1, 1, 0, k0);
    chk("abort_done_latency", 32'(k0), 0);

    // Reset in the middle of a word.
    do_start(4);
    send_byte(8'h11, 0, 0);
    send_byte(8'h22, 0, 0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_mem_write", 32'(mem_write), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_snk_ready", 32'(snk_ready), 0);
    chk("midrst_words_written", 32'(words_written), 0);
    chk("midrst_writedata", mem_writedata, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    bq.delete(); eq.delete();
    for (int i = 0; i < 4; i++) begin bq.push_back(8'($urandom)); eq.push_back(0); end
    run_xfer(bq, eq, 1, 1, 0);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
